phy_apb_cmd_master: RTL and testbench

- RTL APB3 master that drives the PCIe PHY register port (paddr/pwdata/pwrite/psel/penable/pready/prdata/pslverr) on behalf of an upstream command source (firmware sequencer or bench).
- Also contains the post-microcontroller-init PHY reset release sequencer.
- One instance per port (EP, RP), clocked by the link0 core APB clock.
- Replaces behavioural APB tasks and the hand-coded reset release with synthesizable logic.

---
 rtl/phy_apb_cmd_master.sv | 163 ++++++++++++++++
 tb/tb_phy_apb_cmd_master.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/phy_apb_cmd_master.sv
// rtl/phy_apb_cmd_master.sv - APB3 command master for the PCIe PHY register port plus PHY reset release sequencer
module phy_apb_cmd_master #(
  parameter int AWIDTH  = 18,
  parameter int DWIDTH  = 32,
  parameter int RST_DLY = 20,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  input  logic              cmd_write,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [AWIDTH-1:0] phy_apb_paddr,
  output logic [DWIDTH-1:0] phy_apb_pwdata,
  output logic              phy_apb_pwrite,
  output logic              phy_apb_psel,
  output logic              phy_apb_penable,
  input  logic              phy_apb_pready,
  input  logic [DWIDTH-1:0] phy_apb_prdata,
  input  logic              phy_apb_pslverr,
  input  logic              phy_uc_init_complete,
  output logic              phy_reset_n,
  output logic              phy_p00_reset_n
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_SETUP  = 2'd1;
  localparam logic [1:0]  ST_ACCESS = 2'd2;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]  DLY_LOAD  = 8'(RST_DLY);

  logic [1:0]        state_q, state_d;
  logic [AWIDTH-1:0] paddr_q, paddr_d;
  logic [DWIDTH-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              init_prev_q, init_prev_d;
  logic [7:0]        dly_cnt_q, dly_cnt_d;
  logic              phy_reset_n_q, phy_reset_n_d;

  assign cmd_ready = (state_q == ST_IDLE) & ~rst;

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    wait_cnt_d    = wait_cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          pwrite_d  = cmd_write;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = 16'd0;
        state_d    = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready on the final allowed edge still counts as a normal completion
        if (phy_apb_pready || (wait_cnt_q == WAIT_LAST)) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          paddr_d       = '0;
          pwdata_d      = '0;
          pwrite_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = (phy_apb_pready && !pwrite_q) ? phy_apb_prdata : '0;
          rsp_err_d     = phy_apb_pready ? phy_apb_pslverr : 1'b1;
          rsp_timeout_d = ~phy_apb_pready;
          state_d       = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    init_prev_d   = phy_uc_init_complete;
    dly_cnt_d     = dly_cnt_q;
    phy_reset_n_d = phy_reset_n_q;
    // only the first rise arms the delay; release is sticky until rst
    if (phy_uc_init_complete && !init_prev_q && !phy_reset_n_q && (dly_cnt_q == 8'd0)) begin
      dly_cnt_d = DLY_LOAD;
    end else if (dly_cnt_q != 8'd0) begin
      dly_cnt_d = dly_cnt_q - 8'd1;
      if (dly_cnt_q == 8'd1) phy_reset_n_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      wait_cnt_q    <= 16'd0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      init_prev_q   <= 1'b0;
      dly_cnt_q     <= 8'd0;
      phy_reset_n_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      wait_cnt_q    <= wait_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      init_prev_q   <= init_prev_d;
      dly_cnt_q     <= dly_cnt_d;
      phy_reset_n_q <= phy_reset_n_d;
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_err         = rsp_err_q;
  assign rsp_timeout     = rsp_timeout_q;
  assign phy_apb_paddr   = paddr_q;
  assign phy_apb_pwdata  = pwdata_q;
  assign phy_apb_pwrite  = pwrite_q;
  assign phy_apb_psel    = psel_q;
  assign phy_apb_penable = penable_q;
  assign phy_reset_n     = phy_reset_n_q;
  assign phy_p00_reset_n = phy_reset_n_q;

endmodule

// File: tb/tb_phy_apb_cmd_master.sv
// tb/tb_phy_apb_cmd_master.sv - self-checking bench for phy_apb_cmd_master
module tb_phy_apb_cmd_master;

  localparam int TO  = 16;
  localparam int DLY = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [17:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        cmd_write;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [17:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        init_done;
  logic        phy_reset_n;
  logic        phy_p00_reset_n;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  phy_apb_cmd_master #(.AWIDTH(18), .DWIDTH(32), .RST_DLY(DLY), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_write(cmd_write),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .phy_apb_paddr(paddr), .phy_apb_pwdata(pwdata), .phy_apb_pwrite(pwrite),
    .phy_apb_psel(psel), .phy_apb_penable(penable), .phy_apb_pready(pready),
    .phy_apb_prdata(prdata), .phy_apb_pslverr(pslverr),
    .phy_uc_init_complete(init_done), .phy_reset_n(phy_reset_n), .phy_p00_reset_n(phy_p00_reset_n)
  );

  typedef struct {
    logic [17:0] addr;
    logic [31:0] wdata;
    logic        write;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Spec-level response rule: a slave that stalls TO or more cycles is cut off by the timeout
  function automatic void model_rsp(input logic w, input int waits, input logic [31:0] rd,
                                    input logic se, output logic [31:0] e_rd,
                                    output logic e_err, output logic e_to);
    if (waits >= TO) begin
      e_rd = 32'h0; e_err = 1'b1; e_to = 1'b1;
    end else begin
      e_rd = w ? 32'h0 : rd; e_err = se; e_to = 1'b0;
    end
  endfunction

  task automatic run_txn(input logic [17:0] a, input logic [31:0] d, input logic w, input int waits,
                         input logic [31:0] rd, input logic se, input logic [31:0] e_rd,
                         input logic e_err, input logic e_to);
    bit normal;
    int e;
    normal = (waits < TO);
    e = normal ? waits + 2 : TO + 1;
    cmd_addr = a; cmd_wdata = d; cmd_write = w; cmd_valid = 1'b1; pready = 1'b0;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    cmd_addr = 18'($urandom); cmd_wdata = $urandom; cmd_write = 1'($urandom);
    chk("setup_psel_penable", 64'({psel, penable}), 64'b10);
    chk("setup_paddr", 64'(paddr), 64'(a));
    for (int t = 1; t <= e; t++) begin
      pready  = (t == e) && normal;
      prdata  = pready ? rd : $urandom;
      pslverr = pready ? se : 1'($urandom);
      step();
      if (t < e) begin
        chk("access_ctl", 64'({psel, penable, rsp_valid}), 64'b110);
        chk("access_hold", 64'({paddr, pwdata, pwrite}), 64'({a, d, w}));
      end else begin
        chk("rsp_flags", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'({1'b1, e_err, e_to}));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
        chk("apb_idle", 64'({psel, penable, paddr, pwdata, pwrite}), 64'd0);
      end
    end
    pready = 1'b0;
    step();
    chk("rsp_hold", 64'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout}), 64'({1'b0, e_rd, e_err, e_to}));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{18'h3_0068, 32'h1000_0000, 1'b1, 0,  32'hAAAA_5555, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[1] = '{18'h0_0100, 32'h0,         1'b0, 3,  32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[2] = '{18'h0_0200, 32'h0,         1'b0, 40, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b1, 1'b1};
    vecs[3] = '{18'h0_0204, 32'h0,         1'b0, 0,  32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0};
    vecs[4] = '{18'h3_FFFF, 32'hFFFF_FFFF, 1'b0, TO-1, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0};
    vecs[5] = '{18'h0_0004, 32'h5A5A_5A5A, 1'b1, 2,  32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_write = 1'b0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0; init_done = 1'b0;
    step(); step();
    chk("reset_apb", 64'({psel, penable, paddr, pwdata, pwrite}), 64'd0);
    chk("reset_rsp", 64'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout}), 64'd0);
    chk("reset_phy_rst", 64'({phy_reset_n, phy_p00_reset_n}), 64'd0);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

    foreach (vecs[i])
      run_txn(vecs[i].addr, vecs[i].wdata, vecs[i].write, vecs[i].waits, vecs[i].prdata,
              vecs[i].slverr, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_to);

    begin : back_to_back
      int pulses;
      pulses = 0;
      pready = 1'b1; prdata = 32'h0; pslverr = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 18'h0_0010; cmd_wdata = 32'h1111_1111;
      step();
      cmd_addr = 18'h0_0020; cmd_wdata = 32'h2222_2222;
      for (int t = 1; t <= 10; t++) begin
        step();
        if (rsp_valid) pulses++;
        if (t == 2) chk("b2b_overlap", 64'({rsp_valid, cmd_ready}), 64'b11);
        if (t == 3) begin
          chk("b2b_second_setup", 64'({psel, penable, paddr, pwdata}), 64'({2'b10, 18'h0_0020, 32'h2222_2222}));
          cmd_valid = 1'b0;
        end
        if (t == 5) chk("b2b_second_rsp", 64'(rsp_valid), 64'd1);
      end
      chk("b2b_pulses", 64'(pulses), 64'd2);
      pready = 1'b0;
    end

    for (int n = 0; n < 30; n++) begin
      logic [17:0] a;
      logic [31:0] d, rd, e_rd;
      logic w, se, e_err, e_to;
      int waits;
      a = 18'($urandom); d = $urandom; rd = $urandom; w = 1'($urandom); se = 1'($urandom);
      waits = int'($urandom_range(0, TO + 2));
      model_rsp(w, waits, rd, se, e_rd, e_err, e_to);
      run_txn(a, d, w, waits, rd, se, e_rd, e_err, e_to);
    end

    rst = 1'b1; init_done = 1'b0;
    step();
    rst = 1'b0;
    for (int e = 1; e <= 140; e++) begin
      init_done = (e >= 100) && (e < 130) && (e != 104);
      step();
      if (e == 99 || e == 119) chk("seq_not_yet", 64'({phy_reset_n, phy_p00_reset_n}), 64'b00);
      if (e == 120 || e == 125 || e == 140) chk("seq_released", 64'({phy_reset_n, phy_p00_reset_n}), 64'b11);
    end

    rst = 1'b1; init_done = 1'b1;
    step();
    chk("seq_rst_clears", 64'({phy_reset_n, phy_p00_reset_n}), 64'b00);
    rst = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      step();
      if (e == 20) chk("seq_level_not_yet", 64'({phy_reset_n, phy_p00_reset_n}), 64'b00);
      if (e == 21) chk("seq_level_released", 64'({phy_reset_n, phy_p00_reset_n}), 64'b11);
    end
    init_done = 1'b0;

    begin : rst_mid_access
      int pulses;
      pulses = 0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 18'h0_0100; cmd_wdata = 32'h0; pready = 1'b0;
      step();
      cmd_valid = 1'b0;
      step(); step();
      chk("pre_rst_access", 64'({psel, penable}), 64'b11);
      rst = 1'b1;
      step();
      chk("rst_abort_apb", 64'({psel, penable, paddr, rsp_valid}), 64'd0);
      chk("rst_abort_phy", 64'({phy_reset_n, phy_p00_reset_n}), 64'b00);
      chk("rst_cmd_ready_low", 64'(cmd_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("rst_cmd_ready_high", 64'(cmd_ready), 64'd1);
      pready = 1'b1; prdata = 32'hFFFF_FFFF;
      for (int t = 0; t < 4; t++) begin
        step();
        if (rsp_valid) pulses++;
      end
      chk("rst_no_rsp", 64'(pulses), 64'd0);
      pready = 1'b0;
      run_txn(18'h1_2345, 32'h0, 1'b0, 1, 32'h600D_CAFE, 1'b0, 32'h600D_CAFE, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
